// File: rtl/scale_seq_pkg.sv
// Shared constants and state encoding for the scale-stage sequencing controller.
package scale_seq_pkg;

  localparam int DEFAULT_COL_NUM  = 32;
  localparam int DEFAULT_SCALE_W  = 16;
  localparam int DEFAULT_ROW_W    = 16;
  localparam int DEFAULT_PIPE_LAT = 3;

  // Cycles from the last row valid until the last column leaves the scaling
  // stage: the diagonal skew across the columns plus the stage pipeline.
  function automatic int drain_cyc(input int col_num, input int pipe_lat);
    return col_num - 1 + pipe_lat;
  endfunction

  localparam int DEFAULT_DRAIN_CYC = drain_cyc(DEFAULT_COL_NUM, DEFAULT_PIPE_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/scale_bank_dbuf.sv
// Double-buffered scale bank: shadow loads over valid/ready, active drives the
// scaling stage, and a swap strobe copies the whole shadow bank in one edge.
module scale_bank_dbuf #(
  parameter int COL_NUM = 32,
  parameter int SCALE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [SCALE_W-1:0]         load_data,
  output logic                       load_ready,
  input  logic                       swap,
  output logic                       shadow_full,
  output logic [COL_NUM*SCALE_W-1:0] active_flat
);

  localparam int IDX_W = $clog2(COL_NUM);

  logic [COL_NUM-1:0][SCALE_W-1:0] shadow;
  logic [COL_NUM-1:0][SCALE_W-1:0] active;
  logic [IDX_W-1:0]                idx;

  assign load_ready  = !shadow_full;
  assign active_flat = active;

  // Shadow write / wrap and whole-bank copy. Swap only happens while the shadow
  // is full, and loads are refused while full, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      idx         <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (load_valid && load_ready) begin
        shadow[idx] <= load_data;
        if (idx == IDX_W'(COL_NUM - 1)) begin
          idx         <= '0;
          shadow_full <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (swap) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scale_seq_ctrl.sv
// Tile sequencer for the per-column scaling stage: gates array valids during a
// tile, drains skew plus pipeline, and swaps scale banks only between tiles.
//
// state | meaning
// IDLE  | waiting for a full shadow bank and tile_start
// RUN   | forwarding sys_valid, counting rows of the tile
// DRAIN | waiting for skew + scale pipeline to empty; tile_done on last cycle
module scale_seq_ctrl
  import scale_seq_pkg::*;
#(
  parameter int COL_NUM  = DEFAULT_COL_NUM,
  parameter int SCALE_W  = DEFAULT_SCALE_W,
  parameter int ROW_W    = DEFAULT_ROW_W,
  parameter int PIPE_LAT = DEFAULT_PIPE_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scale_in_valid,
  input  logic [SCALE_W-1:0]         scale_in_data,
  output logic                       scale_in_ready,
  input  logic                       tile_start,
  input  logic [ROW_W-1:0]           tile_rows,
  output logic                       tile_start_ready,
  input  logic                       sys_valid,
  output logic                       array_out_valid,
  output logic [COL_NUM*SCALE_W-1:0] col_scale_factors,
  output logic                       busy,
  output logic                       tile_done,
  output logic                       err_stray_valid
);

  localparam int DRAIN_CYC = drain_cyc(COL_NUM, PIPE_LAT);
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);

  state_t             state;
  state_t             state_next;
  logic [ROW_W-1:0]   rows_left;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               shadow_full;
  logic               accept;

  scale_bank_dbuf #(
    .COL_NUM (COL_NUM),
    .SCALE_W (SCALE_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (scale_in_valid),
    .load_data   (scale_in_data),
    .load_ready  (scale_in_ready),
    .swap        (accept),
    .shadow_full (shadow_full),
    .active_flat (col_scale_factors)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_next       = state;
    tile_start_ready = 1'b0;
    accept           = 1'b0;
    array_out_valid  = 1'b0;
    tile_done        = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        tile_start_ready = shadow_full;
        accept           = tile_start && shadow_full;
        if (accept) state_next = (tile_rows == '0) ? DRAIN : RUN;
      end
      RUN: begin
        array_out_valid = sys_valid;
        if (sys_valid && rows_left == ROW_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          tile_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Row and drain counters; drain count is loaded on every entry into DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_left <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) rows_left <= tile_rows;
      else if (state == RUN && sys_valid) rows_left <= rows_left - 1'b1;

      if (state != DRAIN && state_next == DRAIN) drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Sticky flag for array valids arriving while no tile is running.
  always_ff @(posedge clk) begin
    if (rst) err_stray_valid <= 1'b0;
    else if (sys_valid && state != RUN) err_stray_valid <= 1'b1;
  end

endmodule

// File: tb/tb_scale_seq_ctrl.sv
// Bench for scale_seq_ctrl: randomized stimulus against a tile-level timing model.
module tb_scale_seq_ctrl;

  localparam int NCOL  = 32;
  localparam int SW    = 16;
  localparam int DRAIN = NCOL - 1 + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 scale_in_valid;
  logic [SW-1:0]        scale_in_data;
  logic                 scale_in_ready;
  logic                 tile_start;
  logic [15:0]          tile_rows;
  logic                 tile_start_ready;
  logic                 sys_valid;
  logic                 array_out_valid;
  logic [NCOL*SW-1:0]   col_scale_factors;
  logic                 busy;
  logic                 tile_done;
  logic                 err_stray_valid;

  scale_seq_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .scale_in_valid    (scale_in_valid),
    .scale_in_data     (scale_in_data),
    .scale_in_ready    (scale_in_ready),
    .tile_start        (tile_start),
    .tile_rows         (tile_rows),
    .tile_start_ready  (tile_start_ready),
    .sys_valid         (sys_valid),
    .array_out_valid   (array_out_valid),
    .col_scale_factors (col_scale_factors),
    .busy              (busy),
    .tile_done         (tile_done),
    .err_stray_valid   (err_stray_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: banks as arrays, tile progress as row counts and timestamps.
  logic [SW-1:0] m_shadow [NCOL];
  logic [SW-1:0] m_active [NCOL];
  int  m_idx, m_rows, rows_seen, done_cyc, acc_cyc, last_valid_cyc;
  bit  m_full, tile_on, m_err;

  // Values observed at the most recent sample point.
  bit s_busy, s_done, s_tsr, s_sir, s_aov, s_err;
  logic [NCOL*SW-1:0] s_cols;

  logic [SW-1:0] bank_a [NCOL];
  logic [SW-1:0] bank_b [NCOL];

  function automatic bit in_run();
    return tile_on && (rows_seen < m_rows);
  endfunction

  function automatic logic [NCOL*SW-1:0] flat(input logic [SW-1:0] b [NCOL]);
    logic [NCOL*SW-1:0] v;
    for (int i = 0; i < NCOL; i++) v[i*SW +: SW] = b[i];
    return v;
  endfunction

  // One clock of stimulus plus scoreboard update of the reference model.
  task automatic do_cycle(input bit ts, input logic [15:0] rows, input bit sv,
                          input bit lv, input logic [SW-1:0] ld);
    bit e_run, e_done, e_tsr;
    logic [5:0] e_vec, o_vec;
    logic [NCOL*SW-1:0] e_cols;
    tile_start = ts; tile_rows = rows; sys_valid = sv;
    scale_in_valid = lv; scale_in_data = ld;
    @(negedge clk);
    e_run  = in_run();
    e_done = tile_on && (cyc == done_cyc);
    e_tsr  = !tile_on && m_full;
    e_vec  = {tile_on, e_done, e_tsr, !m_full, e_run && sv, m_err};
    e_cols = flat(m_active);
    s_busy = busy; s_done = tile_done; s_tsr = tile_start_ready;
    s_sir = scale_in_ready; s_aov = array_out_valid; s_err = err_stray_valid;
    s_cols = col_scale_factors;
    o_vec  = {s_busy, s_done, s_tsr, s_sir, s_aov, s_err};
    n_checks++;
    if (o_vec !== e_vec) begin
      n_errors++;
      $display("FAIL ctrl_outputs cyc=%0d {busy,done,tsr,sir,aov,err} got %b exp %b",
               cyc, o_vec, e_vec);
    end
    n_checks++;
    if (s_cols !== e_cols) begin
      n_errors++;
      $display("FAIL col_scale cyc=%0d got col0=%h col31=%h exp col0=%h col31=%h",
               cyc, s_cols[SW-1:0], s_cols[NCOL*SW-1 -: SW], e_cols[SW-1:0], e_cols[NCOL*SW-1 -: SW]);
    end
    @(posedge clk);
    if (sv && !e_run) m_err = 1'b1;
    if (e_run && sv) begin
      rows_seen++;
      last_valid_cyc = cyc;
      if (rows_seen == m_rows) done_cyc = cyc + DRAIN;
    end
    if (lv && !m_full) begin
      m_shadow[m_idx] = ld;
      m_idx++;
      if (m_idx == NCOL) begin m_idx = 0; m_full = 1'b1; end
    end
    if (e_done) tile_on = 1'b0;
    if (ts && e_tsr) begin
      for (int i = 0; i < NCOL; i++) m_active[i] = m_shadow[i];
      m_full = 1'b0; tile_on = 1'b1; m_rows = rows; rows_seen = 0; acc_cyc = cyc;
      done_cyc = (rows == 0) ? cyc + DRAIN : -1;
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    tile_start = 0; tile_rows = 0; sys_valid = 0; scale_in_valid = 0; scale_in_data = 0;
    rst = 1'b1;
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    for (int i = 0; i < NCOL; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    m_idx = 0; m_full = 0; tile_on = 0; m_err = 0; m_rows = 0; rows_seen = 0; done_cyc = -1;
  endtask

  // Loads n words from the given bank starting at word 'from', with random idle gaps.
  task automatic load_words(input logic [SW-1:0] b [NCOL], input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      if ($urandom_range(3) == 0) do_cycle(0, 0, 0, 0, 16'h0);
      do_cycle(0, 0, 0, 1, b[k]);
    end
  endtask

  // Runs the current tile to completion with random row valids (and optional bank load).
  task automatic finish_tile(input bit load_b, output int done_at);
    int budget = 400;
    int b_n = 0;
    bit acc;
    done_at = -1;
    while (tile_on && budget > 0) begin
      acc = load_b && !m_full && b_n < NCOL;
      do_cycle($urandom_range(1), 16'h0, in_run() ? 1'($urandom_range(1)) : 1'b0,
               load_b && b_n < NCOL, load_b ? bank_b[b_n % NCOL] : 16'h0);
      if (acc) b_n++;
      if (s_done) done_at = cyc - 1;
      budget--;
    end
    n_checks++;
    if (tile_on) begin
      n_errors++;
      $display("FAIL tile_timeout cyc=%0d busy still %0b exp 0", cyc, s_busy);
      tile_on = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    do_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if ({s_busy, s_done, s_tsr, s_aov, s_err, s_sir} !== 6'b000001 || s_cols !== '0) begin
      n_errors++;
      $display("FAIL reset_state got busy%0b done%0b tsr%0b aov%0b err%0b sir%0b cols_nz%0b exp sir only",
               s_busy, s_done, s_tsr, s_aov, s_err, s_sir, s_cols != '0);
    end
  endtask

  task automatic test_ignore_start();
    for (int n = 0; n < NCOL; n++) bank_a[n] = 16'h3C00 + 16'(n);
    for (int i = 0; i < 3; i++) do_cycle(1, 16'd4, 0, 0, 0);
    for (int k = 0; k < NCOL - 1; k++) do_cycle(1, 16'd4, 0, 1, bank_a[k]);
    do_cycle(1, 16'd4, 0, 0, 0);
    n_checks++;
    if (s_tsr !== 1'b0 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_31_words got tsr=%0b busy=%0b exp 0 0", s_tsr, s_busy);
    end
    do_cycle(0, 0, 0, 1, bank_a[NCOL-1]);
    do_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_tsr !== 1'b1 || s_sir !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_after_32 got tsr=%0b sir=%0b exp 1 0", s_tsr, s_sir);
    end
  endtask

  task automatic test_basic();
    int done_at;
    do_cycle(1, 16'd4, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 0);
    for (int n = 0; n < NCOL; n++) begin
      n_checks++;
      if (s_cols[n*SW +: SW] !== 16'h3C00 + 16'(n)) begin
        n_errors++;
        $display("FAIL basic_col%0d got %h exp %h", n, s_cols[n*SW +: SW], 16'h3C00 + 16'(n));
      end
    end
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 0, 0);
    finish_tile(0, done_at);
    n_checks++;
    if (done_at - last_valid_cyc !== DRAIN) begin
      n_errors++;
      $display("FAIL basic_done_latency got %0d exp %0d", done_at - last_valid_cyc, DRAIN);
    end
    do_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_bank_swap();
    int done_at;
    int sir_low = 0;
    for (int n = 0; n < NCOL; n++) begin bank_a[n] = SW'($urandom); bank_b[n] = SW'($urandom); end
    load_words(bank_a, 0, NCOL);
    do_cycle(1, 16'($urandom_range(3, 8)), 0, 0, 0);
    finish_tile(1, done_at);
    n_checks++;
    if (s_cols !== flat(bank_a) || s_sir !== 1'b0) begin
      n_errors++;
      $display("FAIL bank_a_held got col0=%h sir=%0b exp col0=%h sir=0", s_cols[SW-1:0], s_sir, bank_a[0]);
    end
    do_cycle(1, 16'($urandom_range(1, 4)), 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    if (!s_sir) sir_low++;
    n_checks++;
    if (s_cols !== flat(bank_b)) begin
      n_errors++;
      $display("FAIL bank_b_swap got col0=%h exp col0=%h", s_cols[SW-1:0], bank_b[0]);
    end
    finish_tile(0, done_at);
  endtask

  task automatic test_zero_rows();
    int done_at;
    int aov_cnt = 0;
    for (int n = 0; n < NCOL; n++) bank_a[n] = SW'($urandom);
    load_words(bank_a, 0, NCOL);
    do_cycle(1, 16'd0, 0, 0, 0);
    while (tile_on && cyc < acc_cyc + 100) begin
      do_cycle(0, 0, 0, 0, 0);
      if (s_aov) aov_cnt++;
      if (s_done) done_at = cyc - 1;
    end
    n_checks++;
    if (done_at - acc_cyc !== DRAIN || aov_cnt != 0) begin
      n_errors++;
      $display("FAIL zero_rows got done_lat=%0d aov=%0d exp %0d 0", done_at - acc_cyc, aov_cnt, DRAIN);
    end
  endtask

  task automatic test_stray();
    int done_at;
    do_cycle(0, 0, 1, 0, 0);
    n_checks++;
    if (s_aov !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_forwarded got aov=%0b exp 0", s_aov);
    end
    do_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_err !== 1'b1) begin
      n_errors++;
      $display("FAIL stray_err got %0b exp 1", s_err);
    end
    load_words(bank_a, 0, NCOL);
    do_cycle(1, 16'd5, 0, 0, 0);
    finish_tile(0, done_at);
    do_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (s_err !== 1'b1) begin
      n_errors++;
      $display("FAIL stray_sticky got %0b exp 1", s_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int done_at;
    for (int n = 0; n < NCOL; n++) bank_b[n] = SW'($urandom);
    load_words(bank_a, 0, NCOL);
    do_cycle(1, 16'd4, 0, 0, 0);
    do_cycle(0, 0, 1, 1, bank_b[0]);
    do_cycle(0, 0, 1, 1, bank_b[1]);
    do_reset();
    do_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if ({s_busy, s_done, s_tsr, s_aov, s_err, s_sir} !== 6'b000001 || s_cols !== '0) begin
      n_errors++;
      $display("FAIL mid_reset got busy%0b done%0b tsr%0b aov%0b err%0b sir%0b cols_nz%0b exp sir only",
               s_busy, s_done, s_tsr, s_aov, s_err, s_sir, s_cols != '0);
    end
    for (int n = 0; n < NCOL; n++) bank_a[n] = SW'($urandom);
    load_words(bank_a, 0, NCOL);
    do_cycle(1, 16'($urandom_range(1, 6)), 0, 0, 0);
    finish_tile(0, done_at);
    n_checks++;
    if (done_at - last_valid_cyc !== DRAIN) begin
      n_errors++;
      $display("FAIL post_reset_tile got latency %0d exp %0d", done_at - last_valid_cyc, DRAIN);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_start();
    test_basic();
    test_bank_swap();
    test_zero_rows();
    test_stray();
    test_reset_mid_run();
    do_cycle(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
